// File: rtl/mem_read_arbi_rr.sv
// Round-robin arbiter granting one memory read burst at a time to NUM_CH channels,
// routing returned data/finish to the granted channel, with a per-burst watchdog.
module mem_read_arbi_rr #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned ADDR_BITS     = 24,
    parameter int unsigned LEN_BITS      = 10,
    parameter int unsigned TIMEOUT       = 8000,
    localparam int unsigned CW           = $clog2(NUM_CH)
) (
    input  logic                          mem_clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             ch_rd_burst_req,
    input  logic [NUM_CH*LEN_BITS-1:0]    ch_rd_burst_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]   ch_rd_burst_addr,
    output logic [NUM_CH-1:0]             ch_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]      ch_rd_burst_data,
    output logic [NUM_CH-1:0]             ch_rd_burst_finish,
    output logic [NUM_CH-1:0]             ch_rd_burst_timeout,
    output logic [CW-1:0]                 grant_ch,
    output logic                          busy,
    output logic                          rd_burst_req,
    output logic [LEN_BITS-1:0]           rd_burst_len,
    output logic [ADDR_BITS-1:0]          rd_burst_addr,
    input  logic                          rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0]      rd_burst_data,
    input  logic                          rd_burst_finish
);

    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_ARB   = 3'd0,
        ST_ISSUE = 3'd1,
        ST_READ  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t               state;
    logic [CW-1:0]        rr_ptr;
    logic [WDW-1:0]       wd;
    logic                 wd_expire;
    logic [CW-1:0]        next_ptr;
    logic [NUM_CH-1:0]    elig;
    logic [NUM_CH-1:0]    gsel;
    logic                 pick_ok;
    logic [CW-1:0]        pick_ch;
    logic                 routed;
    logic [LEN_BITS-1:0]  len_a  [NUM_CH];
    logic [ADDR_BITS-1:0] addr_a [NUM_CH];

    // Unpack channel buses; zero-length requests are never eligible.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign len_a[i]  = ch_rd_burst_len[i*LEN_BITS +: LEN_BITS];
        assign addr_a[i] = ch_rd_burst_addr[i*ADDR_BITS +: ADDR_BITS];
        assign elig[i]   = ch_rd_burst_req[i] && (len_a[i] != '0);
    end

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int unsigned k);
        return CW'((32'(base) + k) % NUM_CH);
    endfunction

    // First eligible channel at or after the rr pointer.
    always_comb begin
        pick_ok = 1'b0;
        pick_ch = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!pick_ok && elig[rr_idx(rr_ptr, k)]) begin
                pick_ok = 1'b1;
                pick_ch = rr_idx(rr_ptr, k);
            end
        end
    end

    // Watchdog is cleared in ISSUE, so expiring at TIMEOUT-2 puts ABORT TIMEOUT cycles after ISSUE.
    assign wd_expire = (TIMEOUT != 0) && ((32'(wd) + 32'd2) >= TIMEOUT);
    assign next_ptr  = (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ARB;
            rr_ptr        <= '0;
            grant_ch      <= '0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
            wd            <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (pick_ok) begin
                        grant_ch <= pick_ch;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rd_burst_len  <= len_a[grant_ch];
                    rd_burst_addr <= addr_a[grant_ch];
                    rd_burst_req  <= 1'b1;
                    wd            <= '0;
                    state         <= ST_READ;
                end
                ST_READ: begin
                    if (rd_burst_data_valid) begin
                        rd_burst_req <= 1'b0;
                    end
                    // Finish wins over a coincident watchdog expiry.
                    if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        state        <= ST_DONE;
                    end else if (wd_expire) begin
                        rd_burst_req <= 1'b0;
                        state        <= ST_ABORT;
                    end else if (TIMEOUT != 0) begin
                        wd <= wd + WDW'(1);
                    end
                end
                ST_DONE, ST_ABORT: begin
                    rr_ptr <= next_ptr;
                    state  <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Return path is only open to the granted channel while a burst is live.
    assign gsel   = NUM_CH'(1) << grant_ch;
    assign routed = (state == ST_READ) || (state == ST_DONE);

    assign ch_rd_burst_data_valid = (routed && rd_burst_data_valid) ? gsel : '0;
    assign ch_rd_burst_data       = routed ? rd_burst_data : '0;
    assign ch_rd_burst_finish     = ((state == ST_DONE) || (state == ST_ABORT)) ? gsel : '0;
    assign ch_rd_burst_timeout    = (state == ST_ABORT) ? gsel : '0;
    assign busy = (state == ST_ISSUE) || (state == ST_READ) || (state == ST_DONE);

endmodule
